fwd_hazard_unit: RTL and testbench

Parametrised ID/EX operand latch with integrated forwarding and load-use hazard control for the five-stage MIPS datapath. It captures NPORTS source operands from decode and registers them into the EX stage. It resolves each operand in EX against the EX/MEM, MEM/WB and, optionally, a one-deep writeback hold source. It raises a one-bubble stall on load-use dependencies, generalising the fixed two-source, single-operand forwarding mux.

---
 rtl/fwd_pkg.sv | 9 +
 rtl/fwd_sel_mux.sv | 36 +++
 rtl/fwd_hazard_unit.sv | 81 ++++++++
 tb/tb_fwd_hazard_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: forwarding select codes shared by the hazard unit and its per-port muxes.
package fwd_pkg;
  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_HOLD = 2'b11
  } fwd_sel_t;
endpackage

// File: rtl/fwd_sel_mux.sv
// fwd_sel_mux: resolves one EX operand against the MEM, WB and hold sources.
module fwd_sel_mux
  import fwd_pkg::*;
#(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] raddr,
  input  logic [W-1:0]  rdata,
  input  logic [AW-1:0] mem_dst,
  input  logic          mem_we,
  input  logic          mem_load,
  input  logic [W-1:0]  mem_alu,
  input  logic [AW-1:0] wb_dst,
  input  logic          wb_we,
  input  logic [W-1:0]  wb_wdata,
  input  logic [AW-1:0] hold_dst,
  input  logic          hold_valid,
  input  logic [W-1:0]  hold_data,
  output logic [W-1:0]  op,
  output logic [1:0]    sel
);
  logic nz, mem_hit;
  always_comb begin
    nz      = raddr != '0;
    mem_hit = nz && mem_we && mem_dst == raddr;
    // a load still in MEM has no data yet; the stall guarantees this never matches
    sel = (!nz || (mem_hit && mem_load))    ? FWD_RF   :
          mem_hit                           ? FWD_MEM  :
          (wb_we && wb_dst == raddr)        ? FWD_WB   :
          (hold_valid && hold_dst == raddr) ? FWD_HOLD : FWD_RF;
    op  = sel == FWD_MEM  ? mem_alu   :
          sel == FWD_WB   ? wb_wdata  :
          sel == FWD_HOLD ? hold_data : rdata;
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: ID/EX operand latch with per-port forwarding and load-use stall.
// Define FWD_WB_HOLD_EN to add a one-deep writeback hold source (select code 2'b11).
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int W      = 32,
  parameter int AW     = 5,
  parameter int NPORTS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   flush,
  input  logic                   id_valid,
  input  logic [NPORTS*AW-1:0]   id_raddr,
  input  logic [NPORTS-1:0]      id_ruse,
  input  logic [NPORTS*W-1:0]    id_rdata,
  input  logic [AW-1:0]          id_dst,
  input  logic                   id_we,
  input  logic                   id_load,
  input  logic [AW-1:0]          mem_dst,
  input  logic                   mem_we,
  input  logic                   mem_load,
  input  logic [W-1:0]           mem_alu,
  input  logic [AW-1:0]          wb_dst,
  input  logic                   wb_we,
  input  logic [W-1:0]           wb_wdata,
  output logic                   hazard_stall,
  output logic                   ex_valid,
  output logic [AW-1:0]          ex_dst,
  output logic                   ex_we,
  output logic                   ex_load,
  output logic [NPORTS*W-1:0]    ex_op,
  output logic [2*NPORTS-1:0]    ex_fwd_sel
);
  logic [NPORTS*AW-1:0] ex_raddr;
  logic [NPORTS*W-1:0]  ex_rdata;
  logic [NPORTS-1:0]    ex_ruse, dep, bad;
  logic [AW-1:0]        hold_dst;
  logic [W-1:0]         hold_data;
  logic                 hold_valid;

  assign hazard_stall = id_valid & ~flush & ex_valid & ex_load & ex_we & (ex_dst != '0) & (|dep);

  genvar p;
  generate
    for (p = 0; p < NPORTS; p++) begin : g_port
      assign dep[p] = id_ruse[p] & (id_raddr[p*AW +: AW] == ex_dst);
      assign bad[p] = ex_valid & ex_ruse[p] & (ex_raddr[p*AW +: AW] != '0) & mem_we & mem_load &
                      (mem_dst == ex_raddr[p*AW +: AW]);
      fwd_sel_mux #(.W(W), .AW(AW)) u_mux (
        .raddr(ex_raddr[p*AW +: AW]), .rdata(ex_rdata[p*W +: W]),
        .mem_dst(mem_dst), .mem_we(mem_we), .mem_load(mem_load), .mem_alu(mem_alu),
        .wb_dst(wb_dst), .wb_we(wb_we), .wb_wdata(wb_wdata),
        .hold_dst(hold_dst), .hold_valid(hold_valid), .hold_data(hold_data),
        .op(ex_op[p*W +: W]), .sel(ex_fwd_sel[2*p +: 2])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst)
    if (rst) {ex_valid, ex_dst, ex_we, ex_load, ex_raddr, ex_ruse, ex_rdata} <= '0;
    else if (!freeze)
      {ex_valid, ex_dst, ex_we, ex_load, ex_raddr, ex_ruse, ex_rdata} <= (flush | hazard_stall) ? '0 :
        {id_valid, id_dst, id_we, id_load, id_raddr, id_ruse, id_rdata};

`ifdef FWD_WB_HOLD_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) {hold_valid, hold_dst, hold_data} <= '0;
    else if (!freeze) begin
      hold_valid <= wb_we;
      if (wb_we) {hold_dst, hold_data} <= {wb_dst, wb_wdata};
    end
`else
  assign hold_valid = 1'b0;
  assign hold_dst   = '0;
  assign hold_data  = '0;
`endif

  load_in_mem_chk: assert property (@(posedge clk) disable iff (rst) bad == '0);
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors with a scoreboard queue checked at each falling edge.
module tb_fwd_hazard_unit;
  logic        clk = 1'b0, rst;
  logic        freeze, flush, id_valid, id_we, id_load;
  logic [9:0]  id_raddr;
  logic [1:0]  id_ruse;
  logic [63:0] id_rdata;
  logic [4:0]  id_dst, mem_dst, wb_dst;
  logic        mem_we, mem_load, wb_we;
  logic [31:0] mem_alu, wb_wdata;
  logic        hazard_stall, ex_valid, ex_we, ex_load;
  logic [4:0]  ex_dst;
  logic [63:0] ex_op;
  logic [3:0]  ex_fwd_sel;
  int          n_chk = 0, n_fail = 0;

  typedef struct {
    string       name;
    logic        stall, valid, we, load;
    logic [4:0]  dst;
    logic [63:0] op;
    logic [3:0]  sel;
  } exp_t;
  exp_t q[$];

`ifdef FWD_WB_HOLD_EN
  localparam logic [31:0] HOLD_OP  = 32'h55;
  localparam logic [3:0]  HOLD_SEL = 4'b0011;
`else
  localparam logic [31:0] HOLD_OP  = 32'h0;
  localparam logic [3:0]  HOLD_SEL = 4'b0000;
`endif

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_raddr(id_raddr), .id_ruse(id_ruse), .id_rdata(id_rdata), .id_dst(id_dst),
    .id_we(id_we), .id_load(id_load), .mem_dst(mem_dst), .mem_we(mem_we),
    .mem_load(mem_load), .mem_alu(mem_alu), .wb_dst(wb_dst), .wb_we(wb_we),
    .wb_wdata(wb_wdata), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_dst(ex_dst), .ex_we(ex_we), .ex_load(ex_load), .ex_op(ex_op),
    .ex_fwd_sel(ex_fwd_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input string f, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", n, f, act, req);
    end
  endtask

  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "stall", 64'(hazard_stall), 64'(e.stall));
      chk(e.name, "valid", 64'(ex_valid), 64'(e.valid));
      chk(e.name, "dst",   64'(ex_dst), 64'(e.dst));
      chk(e.name, "we",    64'(ex_we), 64'(e.we));
      chk(e.name, "load",  64'(ex_load), 64'(e.load));
      chk(e.name, "op",    ex_op, e.op);
      chk(e.name, "sel",   64'(ex_fwd_sel), 64'(e.sel));
    end

  task automatic id_set(input logic v, input logic [4:0] r1, r0, input logic [1:0] u,
                        input logic [31:0] d1, d0, input logic [4:0] dst, input logic we, ld);
    {id_valid, id_raddr, id_ruse, id_rdata, id_dst, id_we, id_load} = {v, r1, r0, u, d1, d0, dst, we, ld};
  endtask

  task automatic mem(input logic we, input logic [4:0] dst, input logic ld, input logic [31:0] alu);
    {mem_we, mem_dst, mem_load, mem_alu} = {we, dst, ld, alu};
  endtask

  task automatic wb(input logic we, input logic [4:0] dst, input logic [31:0] d);
    {wb_we, wb_dst, wb_wdata} = {we, dst, d};
  endtask

  task automatic cyc(input string n, input logic st, v, input logic [4:0] dst, input logic we, ld,
                     input logic [31:0] op1, op0, input logic [3:0] sel);
    exp_t e;
    e.name = n; e.stall = st; e.valid = v; e.dst = dst; e.we = we; e.load = ld;
    e.op = {op1, op0}; e.sel = sel;
    q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    id_set(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); mem(0, 0, 0, 0); wb(0, 0, 0);
    cyc("reset", 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    rst = 1'b0;
    id_set(1, 0, 8, 2'b01, 0, 32'h1111, 10, 1, 0);
    cyc("pre_dep", 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    mem(1, 8, 0, 32'h1234); id_set(1, 9, 9, 2'b11, 32'hD1, 32'hD0, 11, 1, 0);
    cyc("mem_fwd", 0, 1, 10, 1, 0, 0, 32'h1234, 4'b0010);
    mem(1, 9, 0, 32'hA); wb(1, 9, 32'hB); id_set(1, 0, 1, 2'b01, 0, 32'h100, 5, 1, 1);
    cyc("double_match", 0, 1, 11, 1, 0, 32'hA, 32'hA, 4'b1010);
    mem(0, 0, 0, 0); wb(0, 0, 0); id_set(1, 5, 2, 2'b11, 0, 32'h22, 6, 1, 0);
    cyc("load_use_stall", 1, 1, 5, 1, 1, 0, 32'h100, 4'b0000);
    mem(1, 5, 1, 32'hDEAD);
    cyc("bubble", 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    mem(0, 0, 0, 0); wb(1, 5, 32'h77); id_set(1, 0, 3, 2'b01, 0, 32'h33, 0, 1, 1);
    cyc("wb_fwd", 0, 1, 6, 1, 0, 32'h77, 32'h22, 4'b0100);
    wb(0, 0, 0); mem(1, 0, 0, 32'h999); id_set(1, 0, 0, 2'b11, 0, 0, 7, 1, 0);
    cyc("load_r0_no_stall", 0, 1, 0, 1, 1, 0, 32'h33, 4'b0000);
    id_set(1, 0, 4, 2'b01, 0, 32'h44, 12, 1, 1);
    cyc("r0_no_fwd", 0, 1, 7, 1, 0, 0, 0, 4'b0000);
    mem(0, 0, 0, 0); id_set(1, 0, 12, 2'b01, 0, 0, 13, 1, 0); flush = 1'b1;
    cyc("flush_vs_stall", 0, 1, 12, 1, 1, 0, 32'h44, 4'b0000);
    flush = 1'b0; id_set(1, 0, 0, 2'b00, 0, 0, 14, 1, 1);
    cyc("flushed", 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    id_set(1, 0, 14, 2'b01, 0, 32'h5, 15, 1, 0); freeze = 1'b1;
    for (int i = 0; i < 3; i++) cyc("freeze_stall", 1, 1, 14, 1, 1, 0, 0, 4'b0000);
    freeze = 1'b0;
    cyc("stall_after_freeze", 1, 1, 14, 1, 1, 0, 0, 4'b0000);
    cyc("bubble2", 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    wb(1, 3, 32'h55); id_set(1, 0, 3, 2'b01, 0, 0, 16, 1, 0);
    cyc("pre_hold", 0, 1, 15, 1, 0, 0, 32'h5, 4'b0000);
    wb(0, 0, 0);
    cyc("hold_fwd", 0, 1, 16, 1, 0, 0, HOLD_OP, HOLD_SEL);
    id_set(1, 0, 0, 2'b00, 0, 0, 20, 1, 1);
    cyc("hold_cleared", 0, 1, 16, 1, 0, 0, 0, 4'b0000);
    id_set(1, 20, 0, 2'b10, 0, 0, 21, 1, 0);
    cyc("load_use2", 1, 1, 20, 1, 1, 0, 0, 4'b0000);
    rst = 1'b1;
    cyc("reset_mid_stall", 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    rst = 1'b0;
    cyc("after_reset", 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
